// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants and decode helper for the ALU decode stage.
// Holds the ALU operation codes, the main-decoder alu_op classes, the R-type
// opcode, the default alu_ctrl width and the combinational decode function.
// The M-extension decode path is selected by the caller through m_en, so the
// RV_M_EXT_EN macro is only interpreted by the top level.
package alu_ctrl_pkg;

  localparam int CTRL_W_DEF = 5;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_MEXT  = 7'b0000001;

  typedef enum logic [1:0] {
    AOP_ADD  = 2'b00,
    AOP_SUB  = 2'b01,
    AOP_FUNC = 2'b10,
    AOP_RSVD = 2'b11
  } alu_op_e;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_code_e;

  typedef struct packed {
    alu_code_e code;
    logic      illegal;
    logic      is_div;   // DIV/DIVU/REM/REMU: multi-cycle
  } dec_t;

  function automatic dec_t decode(input logic [1:0] alu_op,
                                  input logic [6:0] op,
                                  input logic [2:0] func3,
                                  input logic [6:0] func7,
                                  input logic       m_en);
    dec_t d;
    d.code    = ALU_ADD;
    d.illegal = 1'b0;
    d.is_div  = 1'b0;
    case (alu_op)
      AOP_ADD:  d.code = ALU_ADD;
      AOP_SUB:  d.code = ALU_SUB;
      AOP_RSVD: d.illegal = 1'b1;
      default: begin
        if (op == OP_RTYPE && func7 == F7_MEXT) begin
          if (m_en) begin
            // M ops are contiguous from MUL in funct3 order; funct3[2] marks div/rem
            d.code   = alu_code_e'(5'd10 + {2'b00, func3});
            d.is_div = func3[2];
          end else begin
            d.illegal = 1'b1;
          end
        end else begin
          case (func3)
            3'b000:  d.code = (op[5] & func7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  d.code = ALU_SLL;
            3'b010:  d.code = ALU_SLT;
            3'b011:  d.code = ALU_SLTU;
            3'b100:  d.code = ALU_XOR;
            3'b101:  d.code = func7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  d.code = ALU_OR;
            default: d.code = ALU_AND;
          endcase
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_div_timer.sv
// alu_div_timer: occupancy counter for a multi-cycle divide/remainder op.
// Ports: clk, rst (sync active-low), load (start op), flush (abandon op),
// busy (counter non-zero), done (last busy cycle; result valid next cycle).
module alu_div_timer #(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic flush,
  output logic busy,
  output logic done
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || flush)   cnt <= 8'd0;
    else if (load)       cnt <= 8'(DIV_CYCLES);
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  end

  assign busy = (cnt != 8'd0);
  assign done = (cnt == 8'd1);

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: one-slot registered ALU control decode stage.
// Decodes op/func3/func7/alu_op into alu_ctrl + illegal with a valid/ready
// handshake on both sides. Divide/remainder ops hold the slot for
// DIV_CYCLES cycles (busy high) before presenting their output.
// Ports: clk, rst (sync active-low), flush, in_valid/in_ready, op, func3,
// func7, alu_op, out_valid/out_ready, alu_ctrl, illegal, busy.
// Config macro: RV_M_EXT_EN enables M-extension decode and the divide timer;
// without it M-encoded R-type ops decode as illegal ADD and busy is tied 0.
module alu_decode_stage
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [1:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              busy
);

`ifdef RV_M_EXT_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  dec_t dec;
  logic accept;
  logic div_done;

  assign dec      = decode(alu_op, op, func3, func7, M_EN);
  // rst term keeps the stage closed while reset is held
  assign in_ready = rst & (!out_valid | out_ready) & !busy & !flush;
  assign accept   = in_valid & in_ready;

`ifdef RV_M_EXT_EN
  alu_div_timer #(.DIV_CYCLES(DIV_CYCLES)) u_div_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept & dec.is_div),
    .flush (flush),
    .busy  (busy),
    .done  (div_done)
  );
`else
  assign busy     = 1'b0;
  assign div_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      alu_ctrl  <= CTRL_W'(ALU_ADD);
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      // result registers load at accept; a divide only withholds out_valid
      alu_ctrl  <= CTRL_W'(dec.code);
      illegal   <= dec.illegal;
      out_valid <= !dec.is_div;
    end else if (div_done) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
